// File: rtl/sum_collector.sv
// Collects {cout,sum} from a LATENCY-deep pipelined adder into a DEPTH-entry result FIFO.
// Optional macro SUM_CHECK_EN adds a shadow recompute of each sum and a mismatch/err_count checker.
module sum_collector #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [15:0]              in_a,
  input  logic [15:0]              in_b,
  input  logic                     in_cin,
  input  logic [15:0]              add_sum,
  input  logic                     add_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [16:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     mismatch,
  output logic [7:0]               err_count
);
  localparam int AW = $clog2(DEPTH);

  logic [LATENCY-1:0] vld_q;
  logic               cap_valid;
  logic [16:0]        cap_data;
  logic [AW-1:0]      wr_q, rd_q, rd_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [16:0]        mem_q [DEPTH];
  logic [16:0]        head_q, head_d;
  logic               ovf_q;
  logic               pop, push_ok, full_w;

  assign cap_valid = vld_q[LATENCY-1];
  assign cap_data  = {add_cout, add_sum};
  assign full_w    = (cnt_q == (AW+1)'(DEPTH));
  assign pop       = (cnt_q != '0) && out_ready;
  // A full FIFO still takes a capture when the head leaves on the same edge.
  assign push_ok   = cap_valid && (!full_w || pop);

  always_ff @(posedge clk) begin
    if (reset) vld_q <= '0;
    else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_comb begin
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Registered head: the new entry becomes head when it lands at the read slot.
    head_d = head_q;
    if (cnt_d != '0) head_d = (push_ok && rd_d == wr_q) ? cap_data : mem_q[rd_d];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= cap_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= 17'h0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      if (cap_valid && !push_ok) ovf_q <= 1'b1;
    end
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = head_q;
  assign count     = cnt_q;
  assign full      = full_w;
  assign overflow  = ovf_q;

`ifdef SUM_CHECK_EN
  logic [16:0] chk_q [LATENCY];
  logic        mis_q;
  logic [7:0]  err_q;

  always_ff @(posedge clk) begin
    chk_q[0] <= {1'b0, in_a} + {1'b0, in_b} + {16'h0, in_cin};
    for (int i = 1; i < LATENCY; i++) chk_q[i] <= chk_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mis_q <= 1'b0;
      err_q <= 8'h0;
    end else if (cap_valid && chk_q[LATENCY-1] != cap_data) begin
      mis_q <= 1'b1;
      if (err_q != 8'hFF) err_q <= err_q + 8'h1;
    end
  end

  assign mismatch  = mis_q;
  assign err_count = err_q;
`else
  logic unused_chk;
  assign unused_chk = ^{in_a, in_b, in_cin};
  assign mismatch   = 1'b0;
  assign err_count  = 8'h0;
`endif
endmodule

// File: tb/tb_sum_collector.sv
// Bench for sum_collector: pipelined adder model, table vectors, and a pop-side scoreboard.
module tb_sum_collector;
  localparam int LAT = 3;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_cin = 1'b0;
  logic        corrupt = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic [16:0] out_data;
  logic [2:0]  count;
  logic        full, overflow, mismatch;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] exp_q [$];

  sum_collector #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count), .full(full),
    .overflow(overflow), .mismatch(mismatch), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Upstream adder model: LAT-stage pipeline, optional bit-0 corruption.
  logic [16:0] m_pipe [LAT];
  always @(posedge clk) begin
    m_pipe[0] <= in_valid ? (({1'b0, in_a} + {1'b0, in_b} + 17'(in_cin)) ^ {16'h0, corrupt}) : 17'h0;
    for (int i = 1; i < LAT; i++) m_pipe[i] <= m_pipe[i-1];
  end
  assign {add_cout, add_sum} = m_pipe[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_unexpected_pop: got %0h expected none", out_data);
      end else chk("sb_data", out_data, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic cr, input logic keep);
    in_a = a; in_b = b; in_cin = c; corrupt = cr; in_valid = 1'b1;
    if (keep) exp_q.push_back(({1'b0, a} + {1'b0, b} + 17'(c)) ^ {16'h0, cr});
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0; corrupt = 1'b0;
  endtask

  task automatic do_reset();
    idle(); out_ready = 1'b0; reset = 1'b1;
    step(); step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 30 && count != 0; i++) step();
    chk(nm, count, 0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] exp;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    tbl[0] = '{16'd200,  16'd100,  1'b0, 17'h0012C};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b1, 17'h10001};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
    tbl[5] = '{16'h1234, 16'h4321, 1'b1, 17'h05556};

    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_err_count", err_count, 0);

    // Single results through an idle FIFO.
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, 1'b1);
      idle();
      lat = 1;
      while (!out_valid && lat < 10) begin step(); lat++; end
      if (i == 0) chk("latency", lat, 4);
      chk("vec_valid", out_valid, 1);
      chk("vec_data", out_data, tbl[i].exp);
      chk("vec_mismatch", mismatch, 0);
      wait_empty("vec_drain");
    end

    // Six back-to-back launches into a stalled FIFO: last two dropped.
    do_reset();
    for (int i = 0; i < 6; i++) drive(16'(i * 16'h111), 16'h0F0F, i[0], 1'b0, i < 4);
    idle();
    step();
    chk("ovf_count4", count, 4);
    chk("ovf_full", full, 1);
    chk("ovf_pre", overflow, 0);
    step();
    chk("ovf_set", overflow, 1);
    step(); step();
    chk("ovf_count_hold", count, 4);
    out_ready = 1'b1;
    wait_empty("ovf_drain");
    chk("ovf_sticky", overflow, 1);

    // Full FIFO with capture and pop on the same edge.
    do_reset();
    for (int i = 0; i < 4; i++) drive(16'(16'h1000 + i), 16'h0001, 1'b0, 1'b0, 1'b1);
    idle();
    step(); step(); step();
    chk("sim_full", full, 1);
    drive(16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b1);
    idle();
    step(); step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("sim_count", count, 4);
    chk("sim_full_hold", full, 1);
    chk("sim_overflow", overflow, 0);
    out_ready = 1'b1;
    wait_empty("sim_drain");

    // Reset with 3 stored and 2 in flight.
    do_reset();
    for (int i = 0; i < 3; i++) drive(16'(16'h0100 + i), 16'h0002, 1'b0, 1'b0, 1'b1);
    idle();
    step(); step(); step();
    chk("mid_stored", count, 3);
    drive(16'h7777, 16'h0001, 1'b0, 1'b0, 1'b0);
    drive(16'h8888, 16'h0001, 1'b0, 1'b0, 1'b0);
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    chk("mid_count", count, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_overflow", overflow, 0);
    chk("mid_out_data", out_data, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_no_push", count, 0);
    end

    // Corrupted adder results: data passes through, checker counts.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive(16'(16'h2000 + i), 16'h0010, 1'b0, 1'b1, 1'b1);
    idle();
    wait_empty("cor3_drain");
`ifdef SUM_CHECK_EN
    chk("cor3_mismatch", mismatch, 1);
    chk("cor3_err", err_count, 3);
`else
    chk("cor3_mismatch", mismatch, 0);
    chk("cor3_err", err_count, 0);
`endif
    for (int i = 0; i < 297; i++) drive(16'(i), 16'(i * 3), i[1], 1'b1, 1'b1);
    idle();
    wait_empty("cor300_drain");
`ifdef SUM_CHECK_EN
    chk("cor300_err_sat", err_count, 255);
`else
    chk("cor300_err", err_count, 0);
`endif
    chk("sb_empty", exp_q.size(), 0);
    do_reset();
    chk("final_mismatch", mismatch, 0);
    chk("final_err", err_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sum_collector.md
SUM_COLLECTOR -- requirements
Module: sum_collector

Interface
REQ-001 The block SHALL have parameter LATENCY, default 3: cycles from operand launch at the upstream pipelined 16-bit adder to a valid {cout,sum}; legal range 1-8.
REQ-002 The block SHALL have parameter DEPTH, default 4: result FIFO entries; power of two, 2-16.
REQ-003 The block SHALL have port clk, input, 1, the rising-edge clock for all state.
REQ-004 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1: operands are launched into the adder this cycle.
REQ-006 The block SHALL have ports in_a and in_b, input, 16 each, and in_cin, input, 1: the operands launched with in_valid; used only when SUM_CHECK_EN is defined.
REQ-007 The block SHALL have port add_sum, input, 16, the adder sum output.
REQ-008 The block SHALL have port add_cout, input, 1, the adder carry output.
REQ-009 The block SHALL have port out_valid, output, 1: the FIFO head is valid.
REQ-010 The block SHALL have port out_ready, input, 1: the consumer accepts the head.
REQ-011 The block SHALL have port out_data, output, 17, the FIFO head {cout,sum}.
REQ-012 The block SHALL have port count, output, clog2(DEPTH)+1 bits, the current FIFO occupancy.
REQ-013 The block SHALL have port full, output, 1, asserted when count equals DEPTH.
REQ-014 The block SHALL have port overflow, output, 1, a sticky flag for a dropped result.
REQ-015 The block SHALL have port mismatch, output, 1, a sticky flag for a check failure.
REQ-016 The block SHALL have port err_count, output, 8, the number of check failures, saturating.

Function
REQ-017 The block SHALL delay in_valid through a LATENCY-stage shift register; the final tap is cap_valid.
REQ-018 When cap_valid=1, the block SHALL push {add_cout,add_sum}, sampled that cycle, into the FIFO.
REQ-019 A pop SHALL occur on a cycle where out_valid=1 and out_ready=1; the head then advances at the next clock edge.
REQ-020 out_valid SHALL equal (count!=0), driven only from registered state, with no empty-FIFO bypass; a push into an empty FIFO appears on out_valid one cycle later.
REQ-021 out_data SHALL hold the head entry, holding the last value while empty.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 count SHALL update as follows:
- push only: +1
- pop only: -1
- push and pop together: unchanged
REQ-024 A push with full=1 and a simultaneous pop SHALL be accepted, leaving count at DEPTH.
REQ-025 A push with full=1 and no pop SHALL be discarded; FIFO contents SHALL remain unchanged and overflow SHALL set the next cycle.
REQ-026 overflow, mismatch and err_count SHALL clear only on reset.
REQ-027 Arithmetic SHALL be unsigned 16-bit with carry out; no result data SHALL be modified by the block.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL clear the valid shift register, pointers, count, overflow, mismatch and err_count, and set out_data=17'h0.
REQ-029 Reset mid-operation SHALL discard all in-flight and stored results; no push SHALL occur for LATENCY cycles after reset deasserts unless in_valid is raised.
REQ-030 The block SHALL use no asynchronous reset.

Configuration
REQ-031 With macro SUM_CHECK_EN defined, the block SHALL compute in_a+in_b+in_cin as a 17-bit value at launch.
REQ-032 With SUM_CHECK_EN defined, the block SHALL delay that value alongside in_valid.
REQ-033 With SUM_CHECK_EN defined, when cap_valid=1 the block SHALL compare the delayed value to {add_cout,add_sum}.
REQ-034 With SUM_CHECK_EN defined, an inequality SHALL set mismatch and increment err_count, saturating at 255; the pushed data SHALL remain the adder output.
REQ-035 With SUM_CHECK_EN undefined, the check datapath SHALL be absent; in_a, in_b and in_cin SHALL be ignored, and mismatch=0 and err_count=0 constantly.

Verification
REQ-036 The bench SHALL cover: reset held 2 cycles, then in_valid pulse with a=200, b=100, cin=0, adder model LATENCY=3, out_ready=1 -> out_valid rises 4 cycles after launch with out_data=17'h0012C, then count returns to 0.
REQ-037 The bench SHALL cover: a=16'hFFFF, b=16'h0001, cin=1 -> out_data=17'h10001, mismatch stays 0.
REQ-038 The bench SHALL cover: out_ready=0, 6 consecutive launches -> count=4, full=1, overflow=1 after the 5th capture; popped data equals results 1-4 in order.
REQ-039 The bench SHALL cover: FIFO full, simultaneous capture and pop -> count stays 4, overflow stays 0, newest entry is read last.
REQ-040 The bench SHALL cover: with SUM_CHECK_EN, the adder model corrupts sum bit 0 on 3 results -> mismatch=1, err_count=3; on 300 corruptions -> err_count=255.
REQ-041 The bench SHALL cover: reset asserted with 2 results in flight and 3 stored -> count=0, out_valid=0, overflow=0, and no push follows.
